// File: rtl/alu_core_pkg.sv
// alu_core_pkg: shared types and sizing helpers for the alu_core slice.
//   alu_op_t       - 3-bit opcode carried on the alu_in transaction
//   alu_state_t    - control FSM states (IDLE/EXEC/ITER/DONE)
//   result_width   - result width as a function of the operand width
//   iter_cnt_width - width of the iteration counter (clog2 of DATA_WIDTH)
package alu_core_pkg;

   typedef enum logic [2:0] {
      OP_NOP = 3'b000,
      OP_ADD = 3'b001,
      OP_AND = 3'b010,
      OP_XOR = 3'b011,
      OP_MUL = 3'b100,
      OP_DIV = 3'b101,
      OP_ILL = 3'b110,
      OP_RST = 3'b111
   } alu_op_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      ITER = 2'd2,
      DONE = 2'd3
   } alu_state_t;

   function automatic int result_width(input int data_width);
      return 2 * data_width;
   endfunction

   function automatic int iter_cnt_width(input int data_width);
      return (data_width <= 2) ? 1 : $clog2(data_width);
   endfunction

endpackage

// File: rtl/alu_core_iter_arith.sv
// alu_core_iter_arith: iterative unsigned arithmetic, one step per clock.
//   Shift-add multiplier always present; restoring divider only when the
//   macro ALU_CORE_DIV_EN is defined.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   start_i    load operands and begin (sampled with op_i, a_i, b_i)
//   op_i       OP_MUL or OP_DIV; other opcodes do not start the unit
//   a_i, b_i   operands (A = multiplier / dividend, B = multiplicand / divisor)
//   busy_o     high while iterations remain
//   result_o   product, or {remainder, quotient}; all ones on divide by zero
module alu_core_iter_arith
   import alu_core_pkg::*;
#(
   parameter int DATA_WIDTH = 8
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start_i,
   input  alu_op_t                   op_i,
   input  logic [DATA_WIDTH-1:0]     a_i,
   input  logic [DATA_WIDTH-1:0]     b_i,
   output logic                      busy_o,
   output logic [2*DATA_WIDTH-1:0]   result_o
);

   localparam int W  = DATA_WIDTH;
   localparam int CW = iter_cnt_width(DATA_WIDTH);

   logic            busy_q;
   logic [CW-1:0]   cnt_q;
   // Upper half: running partial product / remainder.
   // Lower half: remaining multiplier bits / dividend bits becoming quotient.
   logic [2*W-1:0]  acc_q;
   logic [W-1:0]    b_q;
   logic [2*W-1:0]  step;
   logic            mul_start;
   logic [W:0]      partial;

   assign mul_start = start_i && (op_i == OP_MUL);

   // Multiply step: add B into the upper half when the current multiplier
   // bit is set, then shift the whole accumulator right by one.
   assign partial = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, b_q} : {(W+1){1'b0}});

`ifdef ALU_CORE_DIV_EN
   logic            div_q;
   logic            dz_q;
   logic            div_start;
   logic [W-1:0]    rem_sh;
   logic            ge;
   logic [W-1:0]    rem_n;

   assign div_start = start_i && (op_i == OP_DIV);

   // Restoring step: shift {rem, quo} left; the bit shifted out of rem is
   // the implicit MSB of the shifted remainder, so compare/subtract in W bits.
   assign rem_sh = {acc_q[2*W-2:W], acc_q[W-1]};
   assign ge     = acc_q[2*W-1] || (rem_sh >= b_q);
   assign rem_n  = ge ? (rem_sh - b_q) : rem_sh;

   always_comb begin
      step = {partial, acc_q[W-1:1]};
      if (div_q) step = {rem_n, acc_q[W-2:0], ge};
   end

   assign result_o = dz_q ? {(2*W){1'b1}} : acc_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         div_q <= 1'b0;
         dz_q  <= 1'b0;
      end else if (mul_start || div_start) begin
         div_q <= div_start;
         dz_q  <= div_start && (b_i == '0);
      end
   end

   wire load = mul_start || div_start;
`else
   assign step     = {partial, acc_q[W-1:1]};
   assign result_o = acc_q;

   wire load = mul_start;
`endif

   assign busy_o = busy_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         busy_q <= 1'b0;
         cnt_q  <= '0;
         acc_q  <= '0;
         b_q    <= '0;
      end else if (load) begin
         busy_q <= 1'b1;
         cnt_q  <= '0;
         acc_q  <= {{W{1'b0}}, a_i};
         b_q    <= b_i;
      end else if (busy_q) begin
         acc_q <= step;
         if (cnt_q == CW'(DATA_WIDTH - 1)) begin
            busy_q <= 1'b0;
         end else begin
            cnt_q <= cnt_q + 1'b1;
         end
      end
   end

endmodule

// File: rtl/alu_core.sv
// alu_core: arithmetic unit behind the alu_in handshake, feeding alu_out.
//   Single-cycle add/and/xor, iterative multiply, optional iterative divide
//   (enabled by defining the macro ALU_CORE_DIV_EN; otherwise 101 is illegal).
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   valid_i        transaction valid
//   ready_o        core can accept (high only in IDLE)
//   alu_op_i       opcode (see alu_op_t)
//   a_i, b_i       operands
//   done_o         one-cycle result-valid pulse
//   result_o       2*DATA_WIDTH result, held between updates
//   dbg_state_o    current FSM state for observation
// Handshake: a transaction is taken on a clock edge where valid_i and ready_o
// are both high; opcode and operands are captured on that edge and inputs are
// ignored while ready_o is low. No backpressure exists on the result side.
module alu_core
   import alu_core_pkg::*;
#(
   parameter int DATA_WIDTH = 8
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      valid_i,
   output logic                      ready_o,
   input  logic [2:0]                alu_op_i,
   input  logic [DATA_WIDTH-1:0]     a_i,
   input  logic [DATA_WIDTH-1:0]     b_i,
   output logic                      done_o,
   output logic [2*DATA_WIDTH-1:0]   result_o,
   output alu_state_t                dbg_state_o
);

   localparam int W  = DATA_WIDTH;
   localparam int RW = result_width(DATA_WIDTH);

   alu_state_t     state_q, state_d;
   alu_op_t        op_q, op_d;
   logic [W-1:0]   a_q, a_d, b_q, b_d;
   logic [RW-1:0]  result_q, result_d;
   logic           clr_q, clr_d;

   alu_op_t        in_op;
   logic           in_iter;
   logic           iter_start;
   logic           iter_busy;
   logic [RW-1:0]  iter_res;
   logic [RW-1:0]  exec_res;
   logic [W:0]     add_sum;

   assign in_op = alu_op_t'(alu_op_i);

`ifdef ALU_CORE_DIV_EN
   assign in_iter = (in_op == OP_MUL) || (in_op == OP_DIV);
`else
   assign in_iter = (in_op == OP_MUL);
`endif

   alu_core_iter_arith #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_iter (
      .clk      (clk),
      .rst      (rst),
      .start_i  (iter_start),
      .op_i     (in_op),
      .a_i      (a_i),
      .b_i      (b_i),
      .busy_o   (iter_busy),
      .result_o (iter_res)
   );

   assign add_sum = {1'b0, a_q} + {1'b0, b_q};

   // Single-cycle results; no_op, illegal and (without the divider) 101 give 0.
   always_comb begin
      exec_res = '0;
      case (op_q)
         OP_ADD:  exec_res = {{(W-1){1'b0}}, add_sum};
         OP_AND:  exec_res = {{W{1'b0}}, a_q & b_q};
         OP_XOR:  exec_res = {{W{1'b0}}, a_q ^ b_q};
         default: exec_res = '0;
      endcase
   end

   always_comb begin
      state_d    = state_q;
      op_d       = op_q;
      a_d        = a_q;
      b_d        = b_q;
      result_d   = result_q;
      clr_d      = 1'b0;
      iter_start = 1'b0;
      // rst_op clears the result one edge after it is accepted.
      if (clr_q) result_d = '0;
      case (state_q)
         IDLE: begin
            if (valid_i) begin
               op_d = in_op;
               a_d  = a_i;
               b_d  = b_i;
               if (in_op == OP_RST) begin
                  clr_d = 1'b1;
               end else if (in_iter) begin
                  iter_start = 1'b1;
                  state_d    = ITER;
               end else begin
                  state_d = EXEC;
               end
            end
         end
         EXEC: begin
            result_d = exec_res;
            state_d  = DONE;
         end
         ITER: begin
            if (!iter_busy) begin
               result_d = iter_res;
               state_d  = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         op_q     <= OP_NOP;
         a_q      <= '0;
         b_q      <= '0;
         result_q <= '0;
         clr_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         a_q      <= a_d;
         b_q      <= b_d;
         result_q <= result_d;
         clr_q    <= clr_d;
      end
   end

   assign ready_o     = (state_q == IDLE);
   assign done_o      = (state_q == DONE);
   assign result_o    = result_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_alu_core.sv
module tb_alu_core;
   import alu_core_pkg::*;

   localparam int W = 8;

   // ---------------- clock / reset ----------------
   logic             clk = 1'b0;
   logic             rst;
   logic             valid_i;
   logic [2:0]       alu_op_i;
   logic [W-1:0]     a_i, b_i;
   logic             ready_o, done_o;
   logic [2*W-1:0]   result_o;
   alu_state_t       dbg_state;

   int checks = 0;
   int errors = 0;
   logic [2*W-1:0] exp_q[$];

   always #5 clk = ~clk;

   alu_core #(.DATA_WIDTH(W)) dut (
      .clk         (clk),
      .rst         (rst),
      .valid_i     (valid_i),
      .ready_o     (ready_o),
      .alu_op_i    (alu_op_i),
      .a_i         (a_i),
      .b_i         (b_i),
      .done_o      (done_o),
      .result_o    (result_o),
      .dbg_state_o (dbg_state)
   );

   // ---------------- driver tasks ----------------
   // Present one transaction, let it be accepted on the next posedge, then
   // watch 30 cycles: latency (edges after accept until done seen, -1 if
   // never), first result, cycles with ready low, number of done pulses.
   task automatic drive_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                           output int lat, output logic [2*W-1:0] res,
                           output int rdy_low, output int n_done);
      lat = -1; res = 'x; rdy_low = 0; n_done = 0;
      @(negedge clk);
      valid_i = 1'b1; alu_op_i = op; a_i = a; b_i = b;
      @(posedge clk);
      @(negedge clk);
      valid_i = 1'b0;
      for (int c = 0; c < 30; c++) begin
         if (done_o === 1'b1) begin
            if (n_done == 0) begin
               lat = c;
               res = result_o;
            end
            n_done++;
         end
         if (ready_o !== 1'b1) rdy_low++;
         @(negedge clk);
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset;
      rst = 1'b1; valid_i = 1'b0; alu_op_i = 3'b000; a_i = '0; b_i = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready got %b expected 1", ready_o); end
      checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL reset_done got %b expected 0", done_o); end
      checks++; if (result_o !== 16'h0000) begin errors++; $display("FAIL reset_result got %h expected 0000", result_o); end
      checks++; if (dbg_state !== IDLE) begin errors++; $display("FAIL reset_state got %0d expected %0d", dbg_state, IDLE); end
      rst = 1'b0;
   endtask

   task automatic test_add;
      int lat, rl, nd; logic [2*W-1:0] res;
      drive_op(3'b001, 8'd200, 8'd100, lat, res, rl, nd);
      checks++; if (lat !== 1) begin errors++; $display("FAIL add_latency got %0d expected 1", lat); end
      checks++; if (res !== 16'h012C) begin errors++; $display("FAIL add_result got %h expected 012c", res); end
      checks++; if (rl !== 2) begin errors++; $display("FAIL add_ready_low got %0d expected 2", rl); end
      checks++; if (nd !== 1) begin errors++; $display("FAIL add_done_count got %0d expected 1", nd); end
      checks++; if (result_o !== 16'h012C) begin errors++; $display("FAIL add_result_hold got %h expected 012c", result_o); end
      drive_op(3'b001, 8'd255, 8'd255, lat, res, rl, nd);
      checks++; if (res !== 16'h01FE) begin errors++; $display("FAIL add_carry_result got %h expected 01fe", res); end
   endtask

   task automatic test_nop_illegal;
      int lat, rl, nd; logic [2*W-1:0] res;
      drive_op(3'b000, 8'h55, 8'h66, lat, res, rl, nd);
      checks++; if (lat !== 1) begin errors++; $display("FAIL nop_latency got %0d expected 1", lat); end
      checks++; if (res !== 16'h0000) begin errors++; $display("FAIL nop_result got %h expected 0000", res); end
      drive_op(3'b001, 8'd1, 8'd2, lat, res, rl, nd);
      checks++; if (res !== 16'h0003) begin errors++; $display("FAIL add_small_result got %h expected 0003", res); end
      drive_op(3'b110, 8'hAA, 8'h55, lat, res, rl, nd);
      checks++; if (lat !== 1) begin errors++; $display("FAIL illegal_latency got %0d expected 1", lat); end
      checks++; if (res !== 16'h0000) begin errors++; $display("FAIL illegal_result got %h expected 0000", res); end
      checks++; if (nd !== 1) begin errors++; $display("FAIL illegal_done_count got %0d expected 1", nd); end
   endtask

   task automatic test_back_to_back;
      int n_done = 0;
      bit drop = 1'b0;
      logic [2*W-1:0] e;
      exp_q.push_back(16'h0030);
      exp_q.push_back(16'h00F0);
      @(negedge clk);
      valid_i = 1'b1; alu_op_i = 3'b010; a_i = 8'hF0; b_i = 8'h3C;
      @(posedge clk);
      @(negedge clk);
      // valid stays high with the next transaction while the core is busy
      alu_op_i = 3'b011; a_i = 8'hFF; b_i = 8'h0F;
      for (int c = 0; c < 15; c++) begin
         if (drop) begin
            valid_i = 1'b0;
            drop = 1'b0;
         end else if (valid_i && ready_o) begin
            drop = 1'b1;
         end
         if (done_o === 1'b1) begin
            n_done++;
            checks++;
            if (exp_q.size() == 0) begin
               errors++; $display("FAIL b2b_extra_done got %h expected no pulse", result_o);
            end else begin
               e = exp_q.pop_front();
               if (result_o !== e) begin errors++; $display("FAIL b2b_result got %h expected %h", result_o, e); end
            end
         end
         @(negedge clk);
      end
      valid_i = 1'b0;
      checks++; if (n_done !== 2) begin errors++; $display("FAIL b2b_done_count got %0d expected 2", n_done); end
      exp_q.delete();
   endtask

   task automatic test_mul;
      int lat, rl, nd; logic [2*W-1:0] res;
      drive_op(3'b100, 8'd13, 8'd11, lat, res, rl, nd);
      checks++; if (res !== 16'h008F) begin errors++; $display("FAIL mul_small_result got %h expected 008f", res); end
      drive_op(3'b100, 8'd255, 8'd255, lat, res, rl, nd);
      checks++; if (lat !== 9) begin errors++; $display("FAIL mul_latency got %0d expected 9", lat); end
      checks++; if (res !== 16'hFE01) begin errors++; $display("FAIL mul_result got %h expected fe01", res); end
      checks++; if (rl !== 10) begin errors++; $display("FAIL mul_ready_low got %0d expected 10", rl); end
      checks++; if (nd !== 1) begin errors++; $display("FAIL mul_done_count got %0d expected 1", nd); end
   endtask

   task automatic test_rst_op;
      int nd = 0;
      int rl = 0;
      @(negedge clk);
      valid_i = 1'b1; alu_op_i = 3'b111; a_i = 8'h12; b_i = 8'h34;
      @(posedge clk);
      @(negedge clk);
      valid_i = 1'b0;
      checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL rstop_ready got %b expected 1", ready_o); end
      @(negedge clk);
      checks++; if (result_o !== 16'h0000) begin errors++; $display("FAIL rstop_result got %h expected 0000", result_o); end
      for (int c = 0; c < 10; c++) begin
         if (done_o !== 1'b0) nd++;
         if (ready_o !== 1'b1) rl++;
         @(negedge clk);
      end
      checks++; if (nd !== 0) begin errors++; $display("FAIL rstop_done_count got %0d expected 0", nd); end
      checks++; if (rl !== 0) begin errors++; $display("FAIL rstop_ready_low got %0d expected 0", rl); end
   endtask

   task automatic test_op101;
      int lat, rl, nd; logic [2*W-1:0] res;
`ifdef ALU_CORE_DIV_EN
      drive_op(3'b101, 8'd100, 8'd7, lat, res, rl, nd);
      checks++; if (lat !== 9) begin errors++; $display("FAIL div_latency got %0d expected 9", lat); end
      checks++; if (res !== 16'h020E) begin errors++; $display("FAIL div_result got %h expected 020e", res); end
      drive_op(3'b101, 8'd5, 8'd0, lat, res, rl, nd);
      checks++; if (lat !== 9) begin errors++; $display("FAIL div0_latency got %0d expected 9", lat); end
      checks++; if (res !== 16'hFFFF) begin errors++; $display("FAIL div0_result got %h expected ffff", res); end
`else
      drive_op(3'b001, 8'd3, 8'd4, lat, res, rl, nd);
      checks++; if (res !== 16'h0007) begin errors++; $display("FAIL add_pre101_result got %h expected 0007", res); end
      drive_op(3'b101, 8'd100, 8'd7, lat, res, rl, nd);
      checks++; if (lat !== 1) begin errors++; $display("FAIL op101_latency got %0d expected 1", lat); end
      checks++; if (res !== 16'h0000) begin errors++; $display("FAIL op101_result got %h expected 0000", res); end
`endif
   endtask

   task automatic test_rst_mid_iter;
      int lat, rl, nd; logic [2*W-1:0] res;
      int late_done = 0;
      drive_op(3'b001, 8'd200, 8'd100, lat, res, rl, nd);
      @(negedge clk);
      valid_i = 1'b1; alu_op_i = 3'b100; a_i = 8'd255; b_i = 8'd255;
      @(posedge clk);
      @(negedge clk);            // 1st ITER cycle
      valid_i = 1'b0;
      repeat (3) @(negedge clk); // 4th ITER cycle
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL abort_ready got %b expected 1", ready_o); end
      checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL abort_done got %b expected 0", done_o); end
      checks++; if (result_o !== 16'h0000) begin errors++; $display("FAIL abort_result got %h expected 0000", result_o); end
      for (int c = 0; c < 20; c++) begin
         if (done_o !== 1'b0) late_done++;
         @(negedge clk);
      end
      checks++; if (late_done !== 0) begin errors++; $display("FAIL abort_late_done got %0d expected 0", late_done); end
      drive_op(3'b100, 8'd13, 8'd11, lat, res, rl, nd);
      checks++; if (lat !== 9) begin errors++; $display("FAIL recover_mul_latency got %0d expected 9", lat); end
      checks++; if (res !== 16'h008F) begin errors++; $display("FAIL recover_mul_result got %h expected 008f", res); end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      test_reset();
      test_add();
      test_nop_illegal();
      test_back_to_back();
      test_mul();
      test_rst_op();
      test_op101();
      test_rst_mid_iter();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
